noise_cdf_gen: RTL

- Parametrised inverse-CDF noise sample generator for the SERDES channel model.
- Maps a uniform PROB_W-bit random word to a signed noise amplitude by binary search over a loadable cumulative-threshold table of 2^LEVELS entries.
- The search is fully pipelined, producing one sample per cycle, with ready/valid handshakes on the random input and the noise output.
- Sits between the URNG and the channel summing stage; the table is loaded from host memory before sample generation starts.

---
 rtl/noise_cdf_gen.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/noise_cdf_gen.sv
// Inverse-CDF noise sampler: binary search of a uniform word over a loadable cumulative-threshold table.
// Latency: LEVELS+1 cycles from rand handshake to noise_valid; one sample per cycle when not stalled.
// Backpressure: whole pipeline (output register included) freezes while noise_valid && !noise_ready.
module noise_cdf_gen #(
  parameter int LEVELS = 7,
  parameter int PROB_W = 64,
  parameter int OUT_W  = 8,
  parameter int OFFSET = 2**(LEVELS-1)-1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              ld_valid,
  input  logic [LEVELS-1:0] ld_addr,
  input  logic [PROB_W-1:0] ld_data,
  output logic              table_ready,
  input  logic [PROB_W-1:0] rand_data,
  input  logic              rand_valid,
  output logic              rand_ready,
  output logic [OUT_W-1:0]  noise_out,
  output logic              noise_valid,
  input  logic              noise_ready,
  output logic [CNT_W-1:0]  sample_cnt
);

  localparam int N = 2**LEVELS;
  localparam logic [LEVELS:0]  CNT_FULL = N[LEVELS:0];
  localparam logic [LEVELS:0]  CNT_ONE  = {{LEVELS{1'b0}}, 1'b1};
  localparam logic [OUT_W-1:0] OFS      = OFFSET[OUT_W-1:0];

  // Threshold table; contents survive reset, only the load counter is cleared.
  logic [PROB_W-1:0] tbl_q [N];

  logic [LEVELS:0]   ld_cnt_q, ld_cnt_d;
  logic              tbl_rdy;
  logic              flush;
  logic              adv;
  logic              acc;

  // Per-stage random word, index prefix found so far, and stage valid.
  logic [PROB_W-1:0]             r_q [LEVELS];
  logic [LEVELS-1:0][LEVELS-1:0] pre_q;
  logic [LEVELS-1:0][LEVELS-1:0] pre_d;
  logic [LEVELS-1:0]             v_q;

  logic [OUT_W-1:0] noise_q, noise_d;
  logic             noise_vld_q;
  logic [CNT_W-1:0] cnt_q;

  assign tbl_rdy     = (ld_cnt_q == CNT_FULL);
  // A write to a complete table invalidates everything computed so far.
  assign flush       = ld_valid && tbl_rdy;
  assign adv         = !noise_vld_q || noise_ready;
  // Gating with ld_valid makes a concurrent load win over a rand handshake.
  assign rand_ready  = en && tbl_rdy && !ld_valid && adv;
  assign acc         = rand_valid && rand_ready;

  assign table_ready = tbl_rdy;
  assign noise_out   = noise_q;
  assign noise_valid = noise_vld_q;
  assign sample_cnt  = cnt_q;

  // Load counter: counts every write, saturates at N, restarts at 1 on a write to a full table.
  always_comb begin
    ld_cnt_d = ld_cnt_q;
    if (ld_valid) begin
      ld_cnt_d = tbl_rdy ? CNT_ONE : (ld_cnt_q + CNT_ONE);
    end
  end

  // Load counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ld_cnt_q <= '0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
    end
  end

  // Table write port.
  always_ff @(posedge clk) begin
    if (ld_valid) begin
      tbl_q[ld_addr] <= ld_data;
    end
  end

  // Search stages: stage s decides bit LEVELS-1-s by comparing against T[cand-1].
  for (genvar s = 0; s < LEVELS; s++) begin : g_stage
    localparam int B = LEVELS - 1 - s;
    logic [LEVELS-1:0] cand;
    logic [LEVELS-1:0] addr;
    assign cand     = pre_q[s] | (LEVELS'(1) << B);
    assign addr     = cand - LEVELS'(1);
    assign pre_d[s] = (r_q[s] >= tbl_q[addr]) ? cand : pre_q[s];
  end

  // Final index re-centred around zero, wrapped in OUT_W-bit two's complement.
  assign noise_d = {{(OUT_W-LEVELS){1'b0}}, pre_d[LEVELS-1]} - OFS;

  // Pipeline datapath: no reset needed, validity is tracked separately.
  always_ff @(posedge clk) begin
    if (adv) begin
      r_q[0]   <= rand_data;
      pre_q[0] <= '0;
      for (int s = 1; s < LEVELS; s++) begin
        r_q[s]   <= r_q[s-1];
        pre_q[s] <= pre_d[s-1];
      end
    end
  end

  // Valid chain and output register: flush on table reload, else shift on adv.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q         <= '0;
      noise_vld_q <= 1'b0;
      noise_q     <= '0;
    end else if (flush) begin
      v_q         <= '0;
      noise_vld_q <= 1'b0;
    end else if (adv) begin
      v_q[0] <= acc;
      for (int s = 1; s < LEVELS; s++) begin
        v_q[s] <= v_q[s-1];
      end
      noise_vld_q <= v_q[LEVELS-1];
      if (v_q[LEVELS-1]) begin
        noise_q <= noise_d;
      end
    end
  end

  // Delivered-sample counter, wraps naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (noise_vld_q && noise_ready) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule
